// File: rtl/be_pkg.sv
// Backend shared types for the RV32M divide unit: operation encoding,
// divider FSM states and the fixed divide latency.
package be_pkg;

  localparam int RV32I_INSTRUCTION_WIDTH = 32;

  typedef logic [RV32I_INSTRUCTION_WIDTH-1:0] RV32I_OPERAND_t;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } RV32M_DIV_OP_t;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_CALC  = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_t;

  // Accepting edge to out_valid rising, for the iterative path.
  localparam int RV32M_DIV_LATENCY = 34;

endpackage

// File: rtl/adder_substracter_bmod.sv
// Combinational adder/subtracter: mode=0 gives a+b, mode=1 gives a-b.
// For subtraction carry_out=1 means no borrow (a >= b, unsigned).
module adder_substracter_bmod #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] b_eff;

  // Two's complement subtract: invert b and inject the +1 as carry-in.
  assign b_eff            = mode ? ~b : b;
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode};

endmodule

// File: rtl/rv32m_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (restoring divider).
// Handshake: a request transfers on an edge where in_valid && in_ready;
// a result transfers on an edge where out_valid && out_ready. out_valid
// and result hold until that transfer. flush/rst abort everything.
// Optional macro RV32M_DIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow skip CALC/FIXUP and complete one cycle after acceptance.
// ITER_PER_CYCLE must divide XLEN.
module rv32m_div_unit
  import be_pkg::*;
#(
  parameter int XLEN           = RV32I_INSTRUCTION_WIDTH,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  RV32M_DIV_OP_t   op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output div_state_t      dbg_state
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - ITER_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(ITER_PER_CYCLE);
  localparam logic [XLEN-1:0]  ALL_ONES = '1;
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvs_q, result_q;
  logic             out_valid_q;
  logic             signed_q, is_rem_q, sign_q_q, sign_r_q, div_zero_q, ovf_q;

  // Request decode; |0x80000000| stays 0x80000000 as an unsigned magnitude.
  logic            in_signed, in_is_rem, in_div_zero, in_ovf;
  logic [XLEN-1:0] a_abs, b_abs;
  assign in_signed   = (op == OP_DIV) || (op == OP_REM);
  assign in_is_rem   = (op == OP_REM) || (op == OP_REMU);
  assign a_abs       = (in_signed && a[XLEN-1]) ? -a : a;
  assign b_abs       = (in_signed && b[XLEN-1]) ? -b : b;
  assign in_div_zero = (b == '0);
  assign in_ovf      = in_signed && (a == INT_MIN) && (b == ALL_ONES);

`ifdef RV32M_DIV_EARLY_OUT_EN
  logic            in_special;
  logic [XLEN-1:0] special_result;
  assign in_special     = in_div_zero || in_ovf;
  assign special_result = in_div_zero ? (in_is_rem ? a : ALL_ONES)
                                      : (in_is_rem ? '0 : INT_MIN);
`endif

  // Unrolled restoring steps; each resolves one quotient bit.
  logic [XLEN-1:0] rem_chain [ITER_PER_CYCLE+1];
  logic [XLEN-1:0] quo_chain [ITER_PER_CYCLE+1];
  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar g = 0; g < ITER_PER_CYCLE; g++) begin : g_step
    logic [XLEN:0] shifted, trial;
    logic          no_borrow;
    logic          unused_trial_msb;
    // Partial remainder widened to XLEN+1 so the borrow is explicit.
    assign shifted = {rem_chain[g], quo_chain[g][XLEN-1]};
    adder_substracter_bmod #(.WIDTH(XLEN + 1)) u_trial_sub (
      .a         (shifted),
      .b         ({1'b0, dvs_q}),
      .mode      (1'b1),
      .sum       (trial),
      .carry_out (no_borrow)
    );
    // After a successful trial the result is below the divisor, so its MSB is zero.
    assign unused_trial_msb = trial[XLEN];
    assign rem_chain[g+1]   = no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_chain[g+1]   = {quo_chain[g][XLEN-2:0], no_borrow};
  end

  // Sign correction and RISC-V special-case overrides. Divide-by-zero
  // remainder needs no override: the loop leaves |a|, re-signed to a.
  logic [XLEN-1:0] q_fix, r_fix, fixup_result;
  always_comb begin
    q_fix = (signed_q && sign_q_q) ? -quo_q : quo_q;
    r_fix = (signed_q && sign_r_q) ? -rem_q : rem_q;
    if (div_zero_q)
      fixup_result = is_rem_q ? r_fix : ALL_ONES;
    else if (ovf_q)
      fixup_result = is_rem_q ? '0 : INT_MIN;
    else
      fixup_result = is_rem_q ? r_fix : q_fix;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
`ifdef RV32M_DIV_EARLY_OUT_EN
          state_d = in_special ? DIV_DONE : DIV_CALC;
`else
          state_d = DIV_CALC;
`endif
        end
      end
      DIV_CALC:  if (cnt_q == LAST_CNT) state_d = DIV_FIXUP;
      DIV_FIXUP: state_d = DIV_DONE;
      DIV_DONE:  if (out_valid_q && out_ready) state_d = DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
  end

  // State register; flush acts exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) state_q <= DIV_IDLE;
    else              state_q <= state_d;
  end

  // Datapath registers: operand latch, iteration, result registration.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      signed_q    <= 1'b0;
      is_rem_q    <= 1'b0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // out_valid lags DONE entry by one cycle and drops after the transfer.
      out_valid_q <= (state_q == DIV_DONE) && !(out_valid_q && out_ready);
      case (state_q)
        DIV_IDLE: begin
          if (in_valid) begin
            signed_q   <= in_signed;
            is_rem_q   <= in_is_rem;
            sign_q_q   <= a[XLEN-1] ^ b[XLEN-1];
            sign_r_q   <= a[XLEN-1];
            div_zero_q <= in_div_zero;
            ovf_q      <= in_ovf;
            quo_q      <= a_abs;
            dvs_q      <= b_abs;
            rem_q      <= '0;
            cnt_q      <= '0;
`ifdef RV32M_DIV_EARLY_OUT_EN
            if (in_special) result_q <= special_result;
`endif
          end
        end
        DIV_CALC: begin
          rem_q <= rem_chain[ITER_PER_CYCLE];
          quo_q <= quo_chain[ITER_PER_CYCLE];
          cnt_q <= cnt_q + CNT_STEP;
        end
        DIV_FIXUP: result_q <= fixup_result;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == DIV_IDLE);
  assign busy      = (state_q == DIV_CALC) || (state_q == DIV_FIXUP);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Self-checking bench for rv32m_div_unit: directed RISC-V corner cases,
// result hold/back-to-back, flush and reset aborts, then random traffic
// against a plain-arithmetic reference model.
module tb_rv32m_div_unit;
  import be_pkg::*;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  RV32M_DIV_OP_t op;
  logic [31:0]   a, b, result;
  div_state_t    dbg_state;

  rv32m_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  logic [31:0] exp_q[$];
  int          rise_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        ov_prev = 1'b0;
  bit          rand_ready = 1'b0;

  // Reference model: RISC-V division rules with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_div(input RV32M_DIV_OP_t o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    case (o)
      OP_DIV:  return (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
      OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM:  return (y == 0) ? x : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input RV32M_DIV_OP_t o, input logic [31:0] x, input logic [31:0] y);
    bit special = (y == 0) || ((o == OP_DIV || o == OP_REM) && x == MIN32 && y == 32'hFFFF_FFFF);
`ifdef RV32M_DIV_EARLY_OUT_EN
    return special ? 1 : 34;
`else
    return special ? 34 : 34;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: call at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input RV32M_DIV_OP_t o, input logic [31:0] x, input logic [31:0] y, output int acc_edge);
    int budget = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
      in_valid = 1'b0;
      acc_edge = -1;
      return;
    end
    acc_edge = cyc + 1;
    exp_q.push_back(ref_div(o, x, y));
    rise_q.push_back(acc_edge + ref_lat(o, x, y));
    @(negedge clk);
    in_valid = 1'b0;
    op = RV32M_DIV_OP_t'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      rise_q.delete();
    end
  endtask

  // Abort a divide mid-CALC with flush or rst, then prove recovery.
  task automatic abort_test(input bit use_rst);
    int acc;
    issue(OP_DIVU, 32'd1000000, 32'd3, acc);
    repeat (14) @(negedge clk);
    check(use_rst ? "busy_before_rst" : "busy_before_flush", {31'b0, busy}, 32'd1);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    exp_q.delete();
    rise_q.delete();
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) @(negedge clk);
    issue(OP_DIVU, 32'd9, 32'd3, acc);
    drain();
  endtask

  // Monitor: samples just before each rising edge, checks latency and results.
  always @(negedge clk) begin
    #4;
    if (out_valid && !ov_prev) begin
      if (rise_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_out_valid: out_valid=1 result=%h with no request outstanding", result);
      end else begin
        check("latency", cyc, rise_q.pop_front());
        check("in_ready_while_done", {31'b0, in_ready}, 32'd0);
      end
    end
    ov_prev = out_valid;
    if (out_valid && out_ready && exp_q.size() != 0)
      check("result", result, exp_q.pop_front());
  end

  // Random consumer backpressure during the random phase.
  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  RV32M_DIV_OP_t d_op [12] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REMU,
                               OP_DIV, OP_REM, OP_REM, OP_DIVU, OP_DIV, OP_REMU};
  logic [31:0]   d_a  [12] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'd0,
                               32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0]   d_b  [12] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                               32'd1, 32'd16};

  initial begin
    int acc, hs_edge, budget;
    logic [31:0] hold_exp;
    RV32M_DIV_OP_t ro;
    logic [31:0] ra, rb;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_DIV; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", {30'b0, dbg_state}, {30'b0, DIV_IDLE});
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i], acc);
    drain();

    // Result hold under backpressure, then back-to-back acceptance.
    out_ready = 1'b0;
    hold_exp = ref_div(OP_DIVU, 32'd1000, 32'd10);
    issue(OP_DIVU, 32'd1000, 32'd10, acc);
    budget = 0;
    while (!out_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_result", result, hold_exp);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    hs_edge = cyc + 1;
    @(negedge clk);
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
    issue(OP_REMU, 32'd1000, 32'd7, acc);
    check("b2b_accept_edge", acc, hs_edge + 1);
    drain();

    abort_test(1'b0);
    abort_test(1'b1);

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      ro = RV32M_DIV_OP_t'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = MIN32; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
        3: begin ra = -$urandom_range(0, 1000); rb = $urandom_range(1, 50); end
        4: begin ra = $urandom_range(0, 1000); rb = -$urandom_range(1, 50); end
        default: ;
      endcase
      issue(ro, ra, rb, acc);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
